sprite_anim_ctrl: RTL and testbench
===================================

Name: sprite_anim_ctrl

Overview:
Per-frame controller that sequences the player sprite's walk animation and movement.
- Decodes the keyboard keycode into a facing direction.
- Alternates between the two walk frames (frame 1 / frame 2 ROM select) at a programmable frame rate.
- Gates movement using the collision flag the renderer reports from the background collision map.
- Sits between the keyboard interface, the sprite position logic and the sprite renderer's ROM/palette mux.
- All decisions are taken once per video frame so direction and frame never change mid-frame.

Parameters:
FRAME_DIV, 8, video frames per animation phase (frame_sel toggles every FRAME_DIV frame_start pulses while walking); legal 1..15
CNT_W, 4, width of the animation frame counter; must hold FRAME_DIV-1

Ports:
vga_clk  input  1  pixel clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
keycode  input  8  current USB keycode (0x07 right, 0x04 left, 0x1A up, 0x16 down; anything else = no key)
frame_start  input  1  single-cycle pulse once per video frame (first cycle of vertical blank)
collision  input  1  renderer collision flag, may assert on any cycle of a frame
dir  output  2  facing direction: 00 right, 01 left, 10 up, 11 down
frame_sel  output  1  walk frame select: 0 = frame 1 ROM, 1 = frame 2 ROM
moving  output  1  high while in WALK state
blocked  output  1  high while movement in blocked_dir is suppressed
move_pulse  output  1  one-cycle pulse authorising the position logic to step one unit in dir

Behaviour:
Clock and reset:
- One clock (vga_clk). reset_n is asynchronous, active-low.
- Reset values: dir=11, frame_sel=0, moving=0, blocked=0, move_pulse=0, state=IDLE, anim counter=0, col_seen=0, blocked_dir=11.

Collision latch:
- col_seen is sticky: set on any cycle with collision=1.
- On a frame_start cycle, col_seen is consumed by the update below and then cleared.
- collision=1 on the frame_start cycle itself re-sets col_seen, so it counts toward the next frame.

Key decode (frame_start cycles only; keycode is ignored on all other cycles):
- K_valid = keycode is one of the four codes; K = the mapped direction.

Blocking update (on frame_start, in this order):
- If col_seen=1: blocked<=1, blocked_dir<=current dir.
- Else if !K_valid or K != blocked_dir: blocked<=0.
- Else: blocked holds.
- Let blk_n and bdir_n be the resulting next values of blocked and blocked_dir.

State machine (states IDLE, WALK, PUSH; transitions only on frame_start):
- !K_valid -> IDLE. dir holds (last facing is kept); frame_sel<=0; counter<=0.
- K_valid and !(blk_n and K==bdir_n) -> WALK. dir<=K. Counter increments; when it equals FRAME_DIV-1 it wraps to 0 and frame_sel toggles.
- K_valid and blk_n and K==bdir_n -> PUSH. dir<=K; counter and frame_sel hold.
- Entering WALK from IDLE or PUSH counts that frame_start as the first counter increment.
- A direction change while staying in WALK does not reset the counter.

Outputs:
- moving = (state==WALK), registered.
- move_pulse asserts exactly on the cycle after a frame_start that enters or remains in WALK; otherwise 0.
- Latency: all outputs update on the edge following frame_start; they are stable for the rest of the frame.

Boundary conditions:
- frame_start on consecutive cycles: each pulse is processed independently.
- FRAME_DIV=1: frame_sel toggles on every walking frame.
- Reset asserted mid-frame: all state clears immediately; the first frame_start after release is treated as from IDLE.

Test Plan:
- Reset, keycode=0x07 held, FRAME_DIV=8, 20 frame_start pulses -> dir=00, moving=1, move_pulse once per frame; frame_sel 0->1 after 8th pulse, 1->0 after 16th.
- Walk right 3 frames, then keycode=0x00 -> next frame: moving=0, frame_sel=0, dir stays 00, no move_pulse.
- Keycode=0x1A, collision pulsed mid-frame -> next frame_start: blocked=1, blocked_dir=10, state PUSH, no move_pulse, frame_sel frozen; switch to 0x16 -> blocked=0, dir=11, move_pulse resumes same frame.
- collision asserted only on the frame_start cycle -> no effect that frame; blocked=1 on the following frame_start.
- Keycode changes between frame_start pulses (0x04 then 0x07 mid-frame) -> dir changes only at the next frame_start, to the value present on that cycle.
- Assert reset_n low mid-walk with frame_sel=1 -> all outputs return to reset values asynchronously; after release, first frame_start with 0x04 -> dir=01, move_pulse, frame_sel=0.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
// Player sprite animation and movement sequencer: decodes the keycode into a facing
// direction, alternates the two walk frames and gates stepping on background collisions.
module sprite_anim_ctrl #(
   parameter int FRAME_DIV = 8,
   parameter int CNT_W     = 4
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic [7:0] keycode,
   input  logic       frame_start,
   input  logic       collision,
   output logic [1:0] dir,
   output logic       frame_sel,
   output logic       moving,
   output logic       blocked,
   output logic       move_pulse
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      PUSH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_DIV - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       r_dir;
   logic             r_frameSel;
   logic [CNT_W-1:0] r_cnt;
   logic             r_colSeen;
   logic             r_blocked;
   logic [1:0]       r_blockedDir;
   logic             r_movePulse;

   logic             w_kValid;
   logic [1:0]       w_key;
   logic             w_blkN;
   logic [1:0]       w_bdirN;
   logic             w_pushHit;
   logic [1:0]       w_dirN;
   logic             w_selN;
   logic [CNT_W-1:0] w_cntN;
   logic             w_pulseN;

   always_comb begin
      w_kValid = 1'b1;
      w_key    = 2'b00;
      case (keycode)
         8'h07:   w_key = 2'b00;
         8'h04:   w_key = 2'b01;
         8'h1A:   w_key = 2'b10;
         8'h16:   w_key = 2'b11;
         default: w_kValid = 1'b0;
      endcase
   end

   // A collision seen during the previous frame blocks whatever direction we were facing.
   always_comb begin
      w_blkN  = r_blocked;
      w_bdirN = r_blockedDir;
      if (r_colSeen) begin
         w_blkN  = 1'b1;
         w_bdirN = r_dir;
      end else if (!w_kValid || (w_key != r_blockedDir)) begin
         w_blkN = 1'b0;
      end
      w_pushHit = w_kValid && w_blkN && (w_key == w_bdirN);
   end

   always_comb begin
      w_nextState = r_state;
      if (frame_start) begin
         if (!w_kValid)
            w_nextState = IDLE;
         else if (w_pushHit)
            w_nextState = PUSH;
         else
            w_nextState = WALK;
      end
   end

   always_comb begin
      w_dirN   = r_dir;
      w_selN   = r_frameSel;
      w_cntN   = r_cnt;
      w_pulseN = 1'b0;
      if (frame_start) begin
         case (w_nextState)
            IDLE: begin
               w_selN = 1'b0;
               w_cntN = '0;
            end
            WALK: begin
               w_dirN   = w_key;
               w_pulseN = 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_cntN = '0;
                  w_selN = ~r_frameSel;
               end else begin
                  w_cntN = r_cnt + CNT_W'(1);
               end
            end
            PUSH:    w_dirN = w_key;
            default: w_dirN = r_dir;
         endcase
      end
   end

   // A collision on the frame_start cycle itself belongs to the frame that is starting.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_dir        <= 2'b11;
         r_frameSel   <= 1'b0;
         r_cnt        <= '0;
         r_colSeen    <= 1'b0;
         r_blocked    <= 1'b0;
         r_blockedDir <= 2'b11;
         r_movePulse  <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_dir       <= w_dirN;
         r_frameSel  <= w_selN;
         r_cnt       <= w_cntN;
         r_movePulse <= w_pulseN;
         if (frame_start) begin
            r_colSeen    <= collision;
            r_blocked    <= w_blkN;
            r_blockedDir <= w_bdirN;
         end else if (collision) begin
            r_colSeen <= 1'b1;
         end
      end
   end

   assign dir        = r_dir;
   assign frame_sel  = r_frameSel;
   assign moving     = (r_state == WALK);
   assign blocked    = r_blocked;
   assign move_pulse = r_movePulse;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: hand-computed vector table, directed corner sequences and
// randomized traffic checked against a frame-level behavioural model.
module tb_sprite_anim_ctrl;

   localparam int FRAME_DIV = 8;

   logic       vga_clk;
   logic       reset_n;
   logic [7:0] keycode;
   logic       frame_start;
   logic       collision;
   logic [1:0] dir;
   logic       frame_sel;
   logic       moving;
   logic       blocked;
   logic       move_pulse;

   int checks;
   int failures;

   sprite_anim_ctrl #(.FRAME_DIV(FRAME_DIV), .CNT_W(4)) dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .keycode    (keycode),
      .frame_start(frame_start),
      .collision  (collision),
      .dir        (dir),
      .frame_sel  (frame_sel),
      .moving     (moving),
      .blocked    (blocked),
      .move_pulse (move_pulse)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // Reference model: tracks how many walking frames have elapsed since the last idle,
   // and derives the walk frame from that count directly.
   int mDir, mBdir, mMode, mWalk;
   bit mBlk, mCol, mPulse;

   task automatic modelReset();
      mDir = 3; mBdir = 3; mMode = 0; mWalk = 0;
      mBlk = 0; mCol = 0; mPulse = 0;
   endtask

   task automatic modelStep(input logic [7:0] kc, input logic fs, input logic col);
      bit valid;
      int key;
      valid = 1;
      key   = 0;
      case (kc)
         8'h07:   key = 0;
         8'h04:   key = 1;
         8'h1A:   key = 2;
         8'h16:   key = 3;
         default: valid = 0;
      endcase
      mPulse = 0;
      if (fs) begin
         if (mCol) begin
            mBlk  = 1;
            mBdir = mDir;
         end else if (!valid || key != mBdir) begin
            mBlk = 0;
         end
         if (!valid) begin
            mMode = 0;
            mWalk = 0;
         end else if (mBlk && key == mBdir) begin
            mMode = 2;
            mDir  = key;
         end else begin
            mMode  = 1;
            mDir   = key;
            mWalk  = mWalk + 1;
            mPulse = 1;
         end
         mCol = col;
      end else begin
         mCol = mCol | col;
      end
   endtask

   task automatic cmp(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic checkOutput(input string nm, input logic [1:0] eDir, input logic eSel,
                              input logic eMov, input logic eBlk, input logic ePulse);
      cmp({nm, ".dir"}, dir, eDir);
      cmp({nm, ".frame_sel"}, {1'b0, frame_sel}, {1'b0, eSel});
      cmp({nm, ".moving"}, {1'b0, moving}, {1'b0, eMov});
      cmp({nm, ".blocked"}, {1'b0, blocked}, {1'b0, eBlk});
      cmp({nm, ".move_pulse"}, {1'b0, move_pulse}, {1'b0, ePulse});
   endtask

   task automatic checkModel(input string nm);
      checkOutput(nm, 2'(mDir), ((mWalk / FRAME_DIV) % 2) == 1, mMode == 1, mBlk, mPulse);
   endtask

   task automatic applyStimulus(input logic [7:0] kc, input logic fs, input logic col);
      keycode     = kc;
      frame_start = fs;
      collision   = col;
      @(posedge vga_clk);
      modelStep(kc, fs, col);
      #1;
      frame_start = 1'b0;
      collision   = 1'b0;
   endtask

   // Drops reset between clock edges and checks that outputs clear without a clock.
   task automatic asyncReset(input string nm);
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput(nm, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge vga_clk);
      reset_n = 1'b1;
      #1;
   endtask

   typedef struct {
      logic [7:0] kc;
      logic       fs;
      logic       col;
      logic [1:0] eDir;
      logic       eSel;
      logic       eMov;
      logic       eBlk;
      logic       ePulse;
   } vec_t;

   vec_t vecs[13];

   initial begin
      checks      = 0;
      failures    = 0;
      reset_n     = 1'b0;
      keycode     = 8'h00;
      frame_start = 1'b0;
      collision   = 1'b0;
      modelReset();

      vecs[0]  = '{8'h07, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{8'h04, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{8'h07, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{8'h04, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{8'h04, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{8'h1A, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{8'h1A, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{8'h1A, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{8'h1A, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{8'h16, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{8'h16, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};

      #12;
      checkOutput("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge vga_clk);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].kc, vecs[i].fs, vecs[i].col);
         checkOutput($sformatf("vec%0d", i), vecs[i].eDir, vecs[i].eSel, vecs[i].eMov,
                     vecs[i].eBlk, vecs[i].ePulse);
      end

      // Long walk right: frame 2 ROM after the 8th pulse, back to frame 1 after the 16th.
      asyncReset("rst1");
      for (int p = 1; p <= 20; p++) begin
         applyStimulus(8'h07, 1'b1, 1'b0);
         checkOutput($sformatf("walk%0d", p), 2'd0, (p >= 8 && p < 16), 1'b1, 1'b0, 1'b1);
         applyStimulus(8'h07, 1'b0, 1'b0);
         checkOutput($sformatf("walkgap%0d", p), 2'd0, (p >= 8 && p < 16), 1'b1, 1'b0, 1'b0);
      end
      for (int p = 21; p <= 24; p++) applyStimulus(8'h07, 1'b1, 1'b0);
      checkOutput("walk24", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(8'h07, 1'b0, 1'b0);
      asyncReset("rstmid");
      applyStimulus(8'h04, 1'b1, 1'b0);
      checkOutput("afterrst", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         logic [7:0] kc;
         case ($urandom_range(0, 5))
            0:       kc = 8'h07;
            1:       kc = 8'h04;
            2:       kc = 8'h1A;
            3:       kc = 8'h16;
            4:       kc = 8'h00;
            default: kc = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 399) == 0)
            asyncReset("randrst");
         applyStimulus(kc, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         checkModel("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
